// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient/width types and the decompressor FSM state encoding.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    typedef logic [11:0] coeff_t;
    typedef logic [3:0]  dwidth_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/decompress_core.sv
// Combinational Kyber decompression: round(Q * y / 2^d) with y reduced to its low d bits.
module decompress_core
    import kyber_pkg::*;
#(
    parameter int Q  = KYBER_Q,
    parameter int DW = 12
) (
    input  logic [DW-1:0] y,
    input  dwidth_t       d,
    output logic [DW-1:0] coeff
);

    localparam logic [23:0] QW = 24'(Q);

    logic [23:0] y_mask;
    logic [23:0] prod;
    logic [23:0] rnd;
    logic [23:0] sum;

    // d = 0 is only reachable with the legality check disabled; avoid a negative shift there
    always_comb begin
        y_mask = 24'(y) & ((24'd1 << d) - 24'd1);
        prod   = QW * y_mask;
        rnd    = (d == 4'd0) ? 24'd0 : (24'd1 << (d - 4'd1));
        sum    = prod + rnd;
        coeff  = DW'(sum >> d);
    end

endmodule

// File: rtl/decompress_stream.sv
// Streaming polynomial decompressor: FSM, counters and a 2-stage valid/ready pipeline.
// Optional macro DECOMPRESS_D_CHECK_EN rejects start with d outside 1..12 via an err pulse.
//
// state    | meaning
// ST_IDLE  | waiting for start; d latched when accepted
// ST_RUN   | accepting N_COEFF compressed inputs
// ST_DRAIN | inputs closed, flushing pipeline until out_last handshake
module decompress_stream
    import kyber_pkg::*;
#(
    parameter int N_COEFF = KYBER_N,
    parameter int Q       = KYBER_Q,
    parameter int DW      = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    d_in,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(N_COEFF + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N_COEFF);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_COEFF - 1);

    state_t        state, state_nx;
    dwidth_t       d_reg;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] out_cnt;
    logic          s1_valid;
    logic [DW-1:0] s1_y;
    logic [DW-1:0] core_coeff;
    logic          s1_adv, s2_adv;
    logic          in_hs, out_hs;
    logic          d_ok, start_ok;

`ifdef DECOMPRESS_D_CHECK_EN
    logic err_q;
    assign d_ok = (d_in != 4'd0) && (d_in <= 4'd12);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= (state == ST_IDLE) && start && !d_ok;
    end
    assign err = err_q;
`else
    assign d_ok = 1'b1;
    assign err  = 1'b0;
`endif

    assign start_ok = (state == ST_IDLE) && start && d_ok;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = (state == ST_RUN) && (acc_cnt < CNT_FULL) && s1_adv;
        in_hs    = in_valid && in_ready;
        out_hs   = out_valid && out_ready;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_RUN;
            ST_RUN:   if (in_hs && (acc_cnt == CNT_LAST)) state_nx = ST_DRAIN;
            ST_DRAIN: if (out_hs && out_last) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // counters restart whenever the FSM sits in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg   <= '0;
            acc_cnt <= '0;
            out_cnt <= '0;
            done    <= 1'b0;
        end else begin
            if (start_ok) d_reg <= d_in;
            if (state == ST_IDLE)      acc_cnt <= '0;
            else if (in_hs)            acc_cnt <= acc_cnt + CW'(1);
            if (state == ST_IDLE)      out_cnt <= '0;
            else if (s2_adv && s1_valid) out_cnt <= out_cnt + CW'(1);
            done <= (state == ST_DRAIN) && out_hs && out_last;
        end
    end

    decompress_core #(.Q(Q), .DW(DW)) u_core (
        .y     (s1_y),
        .d     (d_reg),
        .coeff (core_coeff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_y      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_hs;
                if (in_hs) s1_y <= in_data;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= core_coeff;
                    out_last <= (out_cnt == CNT_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_decompress_stream.sv
// Directed self-checking bench for decompress_stream.
module tb_decompress_stream;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  d_in = 4'd0;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = 12'd0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;
    int unsigned yv[N];
    logic [11:0] got[N];

    decompress_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .d_in(d_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned model(input int unsigned y, input int unsigned d);
        int unsigned ym;
        ym = y % (32'd1 << d);
        return (3329 * ym + (32'd1 << (d - 1))) / (32'd1 << d);
    endfunction

    task automatic fill_pattern(input int seed);
        for (int i = 0; i < N; i++) yv[i] = (i * 37 + seed * 101 + $urandom_range(0, 4095)) % 4096;
    endtask

    task automatic run_poly(input logic [3:0] d, input int stall_at, input int stall_len,
                            input int restart_at, input int abort_at, input string tag);
        int ni = 0, no = 0, stall_left = stall_len, budget = 0;
        int first_in = -1, last_in = -1, first_out = -1;
        bit held_v = 0, done_pending = 0, finished = 0;
        bit err_bad = 0, done_bad = 0, drain_bad = 0;
        logic [11:0] held_d;
        logic held_l;
        @(posedge clk); #1;
        start = 1'b1; d_in = d;
        @(posedge clk); #1;
        start = 1'b0; d_in = 4'd3;
        check_cnt++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start actual=%b expected=1", tag, busy);
        else pass_cnt++;
        while (!finished && budget < 3000) begin
            if (budget > 0) begin @(posedge clk); #1; end
            budget++;
            in_valid  = (ni < N);
            in_data   = (ni < N) ? 12'(yv[ni]) : 12'd0;
            start     = (restart_at >= 0 && ni == restart_at);
            d_in      = start ? d + 4'd2 : 4'd3;
            out_ready = !(stall_left > 0 && no == stall_at);
            if (!out_ready) stall_left--;
            if (abort_at >= 0 && ni == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_cnt++;
                if ({in_ready, out_valid, out_data, out_last, busy, done, err} !== 18'd0)
                    $display("FAIL %s async_reset_outputs actual=%h expected=0", tag,
                             {in_ready, out_valid, out_data, out_last, busy, done, err});
                else pass_cnt++;
                in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (err) err_bad = 1;
            if (done_pending) begin
                check_cnt++;
                if (done !== 1'b1) $display("FAIL %s done_pulse actual=%b expected=1", tag, done);
                else pass_cnt++;
                check_cnt++;
                if (busy !== 1'b0) $display("FAIL %s busy_after_done actual=%b expected=0", tag, busy);
                else pass_cnt++;
                done_pending = 0;
                finished = 1;
            end else if (done) done_bad = 1;
            if (ni == N && in_ready) drain_bad = 1;
            if (in_valid && in_ready) begin
                if (first_in < 0) first_in = cyc;
                last_in = cyc;
                ni++;
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    check_cnt++;
                    if (out_data !== held_d || out_last !== held_l)
                        $display("FAIL %s stall_hold actual=%0d/%b expected=%0d/%b", tag, out_data, out_last, held_d, held_l);
                    else pass_cnt++;
                end
                held_v = 1; held_d = out_data; held_l = out_last;
            end else held_v = 0;
            if (out_valid && out_ready && no < N) begin
                got[no] = out_data;
                check_cnt++;
                if (out_data !== 12'(model(yv[no], d)))
                    $display("FAIL %s out_data[%0d] actual=%0d expected=%0d", tag, no, out_data, model(yv[no], d));
                else pass_cnt++;
                check_cnt++;
                if (out_last !== (no == N - 1))
                    $display("FAIL %s out_last[%0d] actual=%b expected=%b", tag, no, out_last, (no == N - 1));
                else pass_cnt++;
                if (no == N - 1) done_pending = 1;
                no++;
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_cnt++;
        if (!finished) $display("FAIL %s timeout outputs=%0d expected=%0d", tag, no, N);
        else pass_cnt++;
        check_cnt++;
        if (first_out - first_in !== 2) $display("FAIL %s latency actual=%0d expected=2", tag, first_out - first_in);
        else pass_cnt++;
        if (stall_len == 0) begin
            check_cnt++;
            if (last_in - first_in !== N - 1)
                $display("FAIL %s throughput actual=%0d expected=%0d", tag, last_in - first_in, N - 1);
            else pass_cnt++;
        end
        check_cnt++;
        if ({err_bad, done_bad, drain_bad} !== 3'b000)
            $display("FAIL %s spurious err/done/drain_ready actual=%b expected=000", tag, {err_bad, done_bad, drain_bad});
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if ({in_ready, out_valid, out_data, out_last, busy, done, err} !== 18'd0)
            $display("FAIL reset_outputs actual=%h expected=0",
                     {in_ready, out_valid, out_data, out_last, busy, done, err});
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        fill_pattern(1);
        yv[0] = 0; yv[1] = 1;
        run_poly(4'd1, -1, 0, -1, -1, "d1");
        check_cnt++;
        if (got[0] !== 12'd0 || got[1] !== 12'd1665)
            $display("FAIL vec_d1 actual=%0d,%0d expected=0,1665", got[0], got[1]);
        else pass_cnt++;
        fill_pattern(2);
        yv[0] = 15;
        run_poly(4'd4, -1, 0, -1, -1, "d4");
        check_cnt++;
        if (got[0] !== 12'd3121) $display("FAIL vec_d4 actual=%0d expected=3121", got[0]);
        else pass_cnt++;
        fill_pattern(3);
        yv[0] = 512; yv[1] = 1023;
        run_poly(4'd10, -1, 0, -1, -1, "d10");
        check_cnt++;
        if (got[0] !== 12'd1665 || got[1] !== 12'd3326)
            $display("FAIL vec_d10 actual=%0d,%0d expected=1665,3326", got[0], got[1]);
        else pass_cnt++;
        fill_pattern(4);
        yv[0] = 4095;
        run_poly(4'd12, -1, 0, -1, -1, "d12");
        check_cnt++;
        if (got[0] !== 12'd3328) $display("FAIL vec_d12 actual=%0d expected=3328", got[0]);
        else pass_cnt++;
    endtask

    task automatic test_stall;
        fill_pattern(5);
        run_poly(4'd11, 100, 5, -1, -1, "stall");
    endtask

    task automatic test_d_check;
`ifdef DECOMPRESS_D_CHECK_EN
        logic [3:0] bad_d[2];
        bad_d[0] = 4'd0; bad_d[1] = 4'd13;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            start = 1'b1; d_in = bad_d[k];
            @(posedge clk); #1;
            start = 1'b0;
            check_cnt++;
            if ({err, busy, in_ready} !== 3'b100)
                $display("FAIL d_check_%0d err/busy/in_ready actual=%b expected=100", bad_d[k], {err, busy, in_ready});
            else pass_cnt++;
            @(posedge clk); #1;
            check_cnt++;
            if ({err, busy, in_ready} !== 3'b000)
                $display("FAIL d_check_%0d after_pulse actual=%b expected=000", bad_d[k], {err, busy, in_ready});
            else pass_cnt++;
        end
`endif
    endtask

    task automatic test_restart_ignored;
        fill_pattern(6);
        run_poly(4'd6, -1, 0, 50, -1, "restart");
    endtask

    task automatic test_reset_midstream;
        fill_pattern(7);
        run_poly(4'd3, -1, 0, -1, 100, "abort");
        fill_pattern(8);
        run_poly(4'd5, -1, 0, -1, -1, "after_abort");
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_stall;
        test_d_check;
        test_restart_ignored;
        test_reset_midstream;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
